// File: rtl/lfsr_fifo_sequencer.sv
// lfsr_fifo_sequencer: sequences LFSR-to-FIFO fills and timed FIFO drains.
// Fill requests one LFSR word at a time (single outstanding request) and stops
// on the programmed length or on FIFO full. Drain pops with a programmed gap
// until the FIFO reports empty. All outputs come straight from registers.
module lfsr_fifo_sequencer #(
  parameter int COUNT_W = 5,
  parameter int GAP_W   = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start_fill,
  input  logic               start_drain,
  input  logic               abort,
  input  logic               auto_drain,
  input  logic [COUNT_W-1:0] fill_len,
  input  logic [GAP_W-1:0]   gap_len,
  input  logic               lfsr_valid,
  input  logic               fifo_full,
  input  logic               fifo_empty,
  output logic               lfsr_enable,
  output logic               fifo_pop,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] fill_cnt
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL_REQ  = 3'd1,
    S_FILL_WAIT = 3'd2,
    S_DRAIN_POP = 3'd3,
    S_DRAIN_GAP = 3'd4
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [COUNT_W-1:0] r_len;
  logic [COUNT_W-1:0] r_fill_cnt;
  logic [GAP_W-1:0]   r_gap_len;
  logic [GAP_W-1:0]   r_gap_cnt;
  logic               r_lfsr_enable;
  logic               r_fifo_pop;
  logic               r_busy;
  logic               r_done;
  logic               w_fill_done;
  logic               w_enable_nxt;
  logic               w_pop_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;

  // Fill ends when the requested count is reached or the FIFO cannot take more.
  assign w_fill_done = (r_fill_cnt == r_len) || fifo_full;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; abort overrides every transition.
  always_comb begin
    w_state_nxt = r_state;
    if (abort) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_fill)       w_state_nxt = S_FILL_REQ;
          else if (start_drain) w_state_nxt = S_DRAIN_POP;
        end
        S_FILL_REQ: begin
          if (w_fill_done) w_state_nxt = auto_drain ? S_DRAIN_POP : S_IDLE;
          else             w_state_nxt = S_FILL_WAIT;
        end
        S_FILL_WAIT: begin
          if (lfsr_valid) w_state_nxt = S_FILL_REQ;
        end
        S_DRAIN_POP: begin
          w_state_nxt = fifo_empty ? S_IDLE : S_DRAIN_GAP;
        end
        S_DRAIN_GAP: begin
          if (r_gap_cnt == '0) w_state_nxt = S_DRAIN_POP;
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: next values of the registered strobes and status flags.
  always_comb begin
    w_enable_nxt = 1'b0;
    w_pop_nxt    = 1'b0;
    w_done_nxt   = 1'b0;
    w_busy_nxt   = (w_state_nxt != S_IDLE);
    if (!abort) begin
      case (r_state)
        S_FILL_REQ: begin
          w_enable_nxt = !w_fill_done;
          w_done_nxt   = w_fill_done && !auto_drain;
        end
        S_DRAIN_POP: begin
          w_pop_nxt  = !fifo_empty;
          w_done_nxt = fifo_empty;
        end
        default: ;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_lfsr_enable <= 1'b0;
      r_fifo_pop    <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_lfsr_enable <= w_enable_nxt;
      r_fifo_pop    <= w_pop_nxt;
      r_busy        <= w_busy_nxt;
      r_done        <= w_done_nxt;
    end
  end

  // Config latches, fill counter (saturating, held on abort) and gap counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_len      <= '0;
      r_fill_cnt <= '0;
      r_gap_len  <= '0;
      r_gap_cnt  <= '0;
    end else if (!abort) begin
      case (r_state)
        S_IDLE: begin
          if (start_fill) begin
            r_len      <= fill_len;
            r_fill_cnt <= '0;
          end else if (start_drain) begin
            r_gap_len  <= gap_len;
          end
        end
        S_FILL_REQ: begin
          if (w_fill_done && auto_drain) r_gap_len <= gap_len;
        end
        S_FILL_WAIT: begin
          if (lfsr_valid && (r_fill_cnt != r_len))
            r_fill_cnt <= r_fill_cnt + COUNT_W'(1);
        end
        S_DRAIN_POP: begin
          if (!fifo_empty) r_gap_cnt <= r_gap_len;
        end
        S_DRAIN_GAP: begin
          if (r_gap_cnt != '0) r_gap_cnt <= r_gap_cnt - GAP_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign lfsr_enable = r_lfsr_enable;
  assign fifo_pop    = r_fifo_pop;
  assign busy        = r_busy;
  assign done        = r_done;
  assign fill_cnt    = r_fill_cnt;

endmodule

// File: tb/tb_lfsr_fifo_sequencer.sv
// Testbench for lfsr_fifo_sequencer with a behavioural LFSR (valid one cycle
// after enable) and a depth-16 FIFO occupancy model.
module tb_lfsr_fifo_sequencer;
  localparam int CW    = 5;
  localparam int GW    = 24;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_fill, start_drain, abort, auto_drain;
  logic [CW-1:0] fill_len;
  logic [GW-1:0] gap_len;
  logic          lfsr_valid;
  logic          fifo_full, fifo_empty;
  logic          lfsr_enable, fifo_pop, busy, done;
  logic [CW-1:0] fill_cnt;

  lfsr_fifo_sequencer #(.COUNT_W(CW), .GAP_W(GW)) dut (
    .clk(clk), .reset_n(reset_n), .start_fill(start_fill), .start_drain(start_drain),
    .abort(abort), .auto_drain(auto_drain), .fill_len(fill_len), .gap_len(gap_len),
    .lfsr_valid(lfsr_valid), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .lfsr_enable(lfsr_enable), .fifo_pop(fifo_pop), .busy(busy), .done(done),
    .fill_cnt(fill_cnt)
  );

  always #5 clk = ~clk;

  // Environment model state (only the main initial block writes these)
  int m_cnt;
  assign fifo_full  = (m_cnt >= DEPTH);
  assign fifo_empty = (m_cnt == 0);

  int n_checks = 0, n_fail = 0;
  int cyc = 0, en_cnt, pop_cnt, done_cnt, last_en, last_pop, spc_err, excl_err;
  int ovf = 0, unf = 0, cur_gap;

  typedef struct {
    int en; int pops; int cnt;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    bit drain; int flen; int glen; bit auto_d; int pre;
    int e_en; int e_pop; int e_cnt; int e_gap; int e_fifo;
  } vec_t;
  vec_t vt[8];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic clr_mon(input int gap);
    en_cnt = 0; pop_cnt = 0; done_cnt = 0; spc_err = 0;
    last_en = -100; last_pop = -100; cur_gap = gap;
  endtask

  // One clock: the model reacts to outputs seen before the edge; outputs are
  // then sampled 1 time unit after the edge.
  task automatic tick();
    logic p_en, p_valid, p_pop;
    p_en = lfsr_enable; p_valid = lfsr_valid; p_pop = fifo_pop;
    @(posedge clk); #1;
    cyc++;
    if (p_valid) begin
      if (m_cnt >= DEPTH) ovf++; else m_cnt++;
    end
    if (p_pop) begin
      if (m_cnt == 0) unf++; else m_cnt--;
    end
    lfsr_valid = p_en;
    if (lfsr_enable) begin
      if (cyc - last_en < 2) spc_err++;
      last_en = cyc; en_cnt++;
    end
    if (fifo_pop) begin
      if (cur_gap != 0 && last_pop >= 0 && (cyc - last_pop) != cur_gap) spc_err++;
      last_pop = cyc; pop_cnt++;
    end
    if (done) begin
      done_cnt++;
      if (busy) excl_err++;
    end
  endtask

  task automatic run_done(input int maxc);
    exp_t e;
    int n = 0;
    while (done_cnt == 0 && n < maxc) begin tick(); n++; end
    chk("done_timeout", int'(done_cnt == 0), 0);
    if (done_cnt != 0) begin
      chk("sb_has_entry", int'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("sb_enables", en_cnt, e.en);
        chk("sb_pops", pop_cnt, e.pops);
        chk("sb_fill_cnt", int'(fill_cnt), e.cnt);
      end
    end
    repeat (4) tick();
    chk("single_done", done_cnt, 1);
    chk("busy_after_done", int'(busy), 0);
  endtask

  initial begin
    exp_t e;
    int n;
    vt[0] = '{0, 3,  0, 0, 0,  3,  0,  3, 0, 3};
    vt[1] = '{0, 20, 0, 0, 0,  16, 0,  16, 0, 16};
    vt[2] = '{1, 0,  5, 0, 4,  0,  4,  16, 7, 0};
    vt[3] = '{0, 2,  0, 1, 0,  2,  2,  2, 2, 0};
    vt[4] = '{0, 0,  0, 0, 0,  0,  0,  0, 0, 0};
    vt[5] = '{0, 31, 0, 0, 10, 6,  0,  6, 0, 16};
    vt[6] = '{1, 0,  3, 0, 0,  0,  0,  6, 0, 0};
    vt[7] = '{0, 5,  1, 1, 14, 2,  16, 2, 3, 0};

    reset_n = 1'b0; start_fill = 0; start_drain = 0; abort = 0; auto_drain = 0;
    fill_len = '0; gap_len = '0; lfsr_valid = 0; m_cnt = 0; excl_err = 0;
    clr_mon(0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_enable", int'(lfsr_enable), 0);
    chk("rst_pop", int'(fifo_pop), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fill_cnt", int'(fill_cnt), 0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Table-driven sequences
    for (int i = 0; i < 8; i++) begin
      m_cnt = vt[i].pre;
      fill_len = CW'(vt[i].flen); gap_len = GW'(vt[i].glen); auto_drain = vt[i].auto_d;
      clr_mon(vt[i].e_gap);
      e.en = vt[i].e_en; e.pops = vt[i].e_pop; e.cnt = vt[i].e_cnt;
      sb.push_back(e);
      if (vt[i].drain) start_drain = 1'b1; else start_fill = 1'b1;
      tick();
      start_fill = 1'b0; start_drain = 1'b0;
      run_done(400);
      chk($sformatf("v%0d_spacing", i), spc_err, 0);
      chk($sformatf("v%0d_fifo_level", i), m_cnt, vt[i].e_fifo);
    end

    // fill_len=0: done exactly two edges after the start pulse, no enable
    m_cnt = 0; fill_len = '0; auto_drain = 0; clr_mon(0);
    start_fill = 1'b1; tick(); start_fill = 1'b0;
    chk("len0_busy_c1", int'(busy), 1);
    chk("len0_done_c1", int'(done), 0);
    tick();
    chk("len0_done_c2", int'(done), 1);
    chk("len0_busy_c2", int'(busy), 0);
    chk("len0_enables", en_cnt, 0);

    // Simultaneous starts: fill wins; start_drain in FILL_WAIT ignored
    m_cnt = 4; fill_len = CW'(2); gap_len = GW'(0); clr_mon(0);
    e.en = 2; e.pops = 0; e.cnt = 2; sb.push_back(e);
    start_fill = 1'b1; start_drain = 1'b1; tick();
    start_fill = 1'b0; start_drain = 1'b0;
    n = 0;
    while (en_cnt == 0 && n < 20) begin tick(); n++; end
    chk("both_first_enable", en_cnt, 1);
    start_drain = 1'b1; tick(); start_drain = 1'b0;
    run_done(100);
    chk("both_fifo_level", m_cnt, 6);

    // Abort in FILL_WAIT after one word counted
    m_cnt = 0; fill_len = CW'(5); clr_mon(0);
    start_fill = 1'b1; tick(); start_fill = 1'b0;
    n = 0;
    while (en_cnt < 2 && n < 40) begin tick(); n++; end
    chk("abf_second_enable", en_cnt, 2);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abf_busy", int'(busy), 0);
    chk("abf_enable", int'(lfsr_enable), 0);
    chk("abf_done", int'(done), 0);
    chk("abf_fill_cnt", int'(fill_cnt), 1);
    repeat (10) tick();
    chk("abf_no_more_enables", en_cnt, 2);
    chk("abf_no_done", done_cnt, 0);
    chk("abf_fill_cnt_hold", int'(fill_cnt), 1);
    chk("abf_word_landed", m_cnt, 2);

    // Abort in DRAIN_GAP
    m_cnt = 6; gap_len = GW'(4); clr_mon(6);
    start_drain = 1'b1; tick(); start_drain = 1'b0;
    n = 0;
    while (pop_cnt == 0 && n < 20) begin tick(); n++; end
    chk("abd_first_pop", pop_cnt, 1);
    abort = 1'b1; tick(); abort = 1'b0;
    chk("abd_busy", int'(busy), 0);
    chk("abd_pop", int'(fifo_pop), 0);
    repeat (20) tick();
    chk("abd_no_more_pops", pop_cnt, 1);
    chk("abd_no_done", done_cnt, 0);
    chk("abd_fifo_level", m_cnt, 5);

    // Reset asserted mid-drain clears outputs asynchronously
    m_cnt = 6; gap_len = GW'(0); clr_mon(2);
    start_drain = 1'b1; tick(); start_drain = 1'b0;
    n = 0;
    while (pop_cnt == 0 && n < 20) begin tick(); n++; end
    chk("rst_mid_pop_seen", int'(fifo_pop), 1);
    reset_n = 1'b0; #1;
    chk("rst_mid_pop", int'(fifo_pop), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_fill_cnt", int'(fill_cnt), 0);
    #1 reset_n = 1'b1;
    repeat (5) tick();
    chk("rst_mid_idle", int'(busy), 0);
    chk("rst_mid_pops", pop_cnt, 1);
    chk("rst_mid_fifo_level", m_cnt, 6);

    chk("overflow_pushes", ovf, 0);
    chk("underflow_pops", unf, 0);
    chk("done_busy_excl", excl_err, 0);
    chk("sb_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
